// File: rtl/bram_bank_arbiter.sv
// Two-port arbiter in front of one registered-read block-RAM bank; sequences read latency back to the owner.
// Optional round-robin arbitration when BRAM_ARB_RR_EN is defined (fixed A > B otherwise).
module bram_bank_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                a_req,
    input  logic                a_we,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W-1:0]   a_wdata,
    input  logic [DATA_W/8-1:0] a_wben,
    output logic                a_gnt,
    output logic                a_rvalid,
    output logic [DATA_W-1:0]   a_rdata,
    input  logic                b_req,
    input  logic                b_we,
    input  logic [ADDR_W-1:0]   b_addr,
    input  logic [DATA_W-1:0]   b_wdata,
    input  logic [DATA_W/8-1:0] b_wben,
    output logic                b_gnt,
    output logic                b_rvalid,
    output logic [DATA_W-1:0]   b_rdata,
    output logic                ram_re,
    output logic [ADDR_W-1:0]   ram_raddr,
    output logic                ram_we,
    output logic [ADDR_W-1:0]   ram_waddr,
    output logic [DATA_W-1:0]   ram_wdata,
    output logic [DATA_W/8-1:0] ram_wben,
    input  logic [DATA_W-1:0]   ram_rdata
);
    localparam int BE_W = DATA_W / 8;
    localparam logic [1:0] LAT_INIT = 2'(RD_LAT);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t     state_reg, state_next;
    logic [1:0] cnt_reg, cnt_next;
    logic       owner_reg, owner_next;   // 0 = A, 1 = B
    logic       idle_ok, prio_a, grant_a, grant_b, any_grant, rd_done;
    logic       win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic [BE_W-1:0]   win_wben;

`ifdef BRAM_ARB_RR_EN
    logic last_gnt_reg;   // 0 = A, 1 = B

    always_ff @(posedge clk) begin
        if (reset)
            last_gnt_reg <= 1'b1;
        else if (any_grant)
            last_gnt_reg <= grant_b;
    end

    // The port that did not win last time gets precedence on a conflict.
    assign prio_a = last_gnt_reg;
`else
    assign prio_a = 1'b1;
`endif

    assign idle_ok   = (state_reg == IDLE) && !reset;
    assign grant_a   = idle_ok && a_req && (!b_req || prio_a);
    assign grant_b   = idle_ok && b_req && !grant_a;
    assign any_grant = grant_a || grant_b;
    assign win_we    = grant_b ? b_we    : a_we;
    assign win_addr  = grant_b ? b_addr  : a_addr;
    assign win_wdata = grant_b ? b_wdata : a_wdata;
    assign win_wben  = grant_b ? b_wben  : a_wben;
    assign rd_done   = (state_reg == RD_WAIT) && (cnt_reg == 2'd0) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 2'd0;
            owner_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            owner_reg <= owner_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        owner_next = owner_reg;
        case (state_reg)
            IDLE: begin
                if (any_grant && !win_we) begin
                    state_next = RD_WAIT;
                    cnt_next   = LAT_INIT;
                    owner_next = grant_b;
                end
            end
            RD_WAIT: begin
                if (cnt_reg == 2'd0)
                    state_next = IDLE;
                else
                    cnt_next = cnt_reg - 2'd1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        a_gnt     = grant_a;
        b_gnt     = grant_b;
        ram_re    = 1'b0;
        ram_raddr = '0;
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdata = '0;
        ram_wben  = '0;
        a_rvalid  = rd_done && !owner_reg;
        b_rvalid  = rd_done && owner_reg;
        if (any_grant) begin
            if (win_we) begin
                ram_we    = 1'b1;
                ram_waddr = win_addr;
                ram_wdata = win_wdata;
                ram_wben  = win_wben;
            end else begin
                ram_re    = 1'b1;
                ram_raddr = win_addr;
            end
        end
    end

    // Returned data is forced to zero on each lane outside the owner's rvalid cycle.
    genvar gi;
    generate
        for (gi = 0; gi < BE_W; gi++) begin : g_lane
            assign a_rdata[gi*8 +: 8] = a_rvalid ? ram_rdata[gi*8 +: 8] : 8'h00;
            assign b_rdata[gi*8 +: 8] = b_rvalid ? ram_rdata[gi*8 +: 8] : 8'h00;
        end
    endgenerate

endmodule

// File: tb/tb_bram_bank_arbiter.sv
// Directed bench: two arbiter instances (read latency 1 and 3) share stimulus, each with its own RAM model.
module tb_bram_bank_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
    logic [9:0]  a_addr = 0, b_addr = 0;
    logic [31:0] a_wdata = 0, b_wdata = 0;
    logic [3:0]  a_wben = 0, b_wben = 0;

    logic        a_gnt [2], a_rvalid [2], b_gnt [2], b_rvalid [2];
    logic [31:0] a_rdata [2], b_rdata [2];
    logic        ram_re [2], ram_we [2];
    logic [9:0]  ram_raddr [2], ram_waddr [2];
    logic [31:0] ram_wdata [2], ram_rdata [2];
    logic [3:0]  ram_wben [2];

    int n_cmp = 0;
    int n_fail = 0;
    int lat_of [2] = '{1, 3};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            localparam int L = (gi == 0) ? 1 : 3;
            logic [31:0] mem  [0:1023];
            logic [31:0] pipe [0:L-1];

            bram_bank_arbiter #(.ADDR_W(10), .DATA_W(32), .RD_LAT(L)) u_dut (
                .clk(clk), .reset(reset),
                .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_wben(a_wben),
                .a_gnt(a_gnt[gi]), .a_rvalid(a_rvalid[gi]), .a_rdata(a_rdata[gi]),
                .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_wben(b_wben),
                .b_gnt(b_gnt[gi]), .b_rvalid(b_rvalid[gi]), .b_rdata(b_rdata[gi]),
                .ram_re(ram_re[gi]), .ram_raddr(ram_raddr[gi]),
                .ram_we(ram_we[gi]), .ram_waddr(ram_waddr[gi]),
                .ram_wdata(ram_wdata[gi]), .ram_wben(ram_wben[gi]),
                .ram_rdata(ram_rdata[gi])
            );

            // Registered-read RAM: output holds its last value until the next read.
            always_ff @(posedge clk) begin
                if (ram_we[gi])
                    for (int b = 0; b < 4; b++)
                        if (ram_wben[gi][b])
                            mem[ram_waddr[gi]][b*8 +: 8] <= ram_wdata[gi][b*8 +: 8];
                if (ram_re[gi])
                    pipe[0] <= mem[ram_raddr[gi]];
                for (int k = 1; k < L; k++)
                    pipe[k] <= pipe[k-1];
            end
            assign ram_rdata[gi] = pipe[L-1];
        end
    endgenerate

    typedef struct {
        logic        a_req;
        logic [9:0]  a_addr;
        logic [31:0] a_wdata;
        logic [3:0]  a_wben;
        logic        b_req;
        logic [9:0]  b_addr;
        logic [31:0] b_wdata;
        logic [3:0]  b_wben;
        logic        e_a_gnt;
        logic        e_b_gnt;
        logic        e_we;
        logic [9:0]  e_waddr;
        logic [31:0] e_wdata;
        logic [3:0]  e_wben;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d actual=%h required=%h", nm, inst, act, exp);
        end
    endtask

    function automatic logic [31:0] outs_or(input int i);
        return {31'b0, |{a_gnt[i], a_rvalid[i], a_rdata[i], b_gnt[i], b_rvalid[i], b_rdata[i],
                        ram_re[i], ram_raddr[i], ram_we[i], ram_waddr[i], ram_wdata[i], ram_wben[i]}};
    endfunction

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        a_req = 0; b_req = 0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) chk("reset_outputs", i, outs_or(i), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        $display("reset sequence done");
    endtask

    task automatic do_read(input bit port_b, input logic [9:0] addr, input logic [31:0] exp);
        int pulses [2];
        int i;
        pulses = '{0, 0};
        @(posedge clk); #1;
        if (port_b) begin b_req = 1; b_we = 0; b_addr = addr; end
        else        begin a_req = 1; a_we = 0; a_addr = addr; end
        @(negedge clk);
        for (i = 0; i < 2; i++) begin
            chk("rd_gnt", i, {30'b0, a_gnt[i], b_gnt[i]}, port_b ? 32'd1 : 32'd2);
            chk("rd_re", i, {31'b0, ram_re[i]}, 1);
            chk("rd_raddr", i, {22'b0, ram_raddr[i]}, {22'b0, addr});
        end
        @(posedge clk); #1;
        a_req = 0; b_req = 0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            for (i = 0; i < 2; i++) begin
                chk("rd_other_rvalid", i, {31'b0, port_b ? a_rvalid[i] : b_rvalid[i]}, 0);
                if (port_b ? b_rvalid[i] : a_rvalid[i]) begin
                    pulses[i]++;
                    chk("rd_latency", i, cyc, lat_of[i] + 1);
                    chk("rd_data", i, port_b ? b_rdata[i] : a_rdata[i], exp);
                end
            end
        end
        for (i = 0; i < 2; i++) chk("rd_pulses", i, pulses[i], 1);
        $display("read port=%s addr=%h expect=%h", port_b ? "B" : "A", addr, exp);
    endtask

    initial begin
        logic        last_m;
        logic        e_a, e_b;
        logic [9:0]  e_addr;
        logic [31:0] e_data;
        logic [3:0]  e_be;
        int          ng [2];
        logic        last_own [2];
        int          b_cyc [2];
        int          a_cyc [2];

        vecs[0] = '{1'b1, 10'h005, 32'hDEADBEEF, 4'hF, 1'b0, 10'h000, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1, 10'h005, 32'hDEADBEEF, 4'hF};
        vecs[1] = '{1'b0, 10'h000, 32'h0, 4'h0, 1'b1, 10'h3FF, 32'hCAFEF00D, 4'hF, 1'b0, 1'b1, 1'b1, 10'h3FF, 32'hCAFEF00D, 4'hF};
        vecs[2] = '{1'b1, 10'h010, 32'h11223344, 4'hF, 1'b1, 10'h020, 32'h55667788, 4'hF, 1'b1, 1'b0, 1'b1, 10'h010, 32'h11223344, 4'hF};
        vecs[3] = '{1'b0, 10'h000, 32'h0, 4'h0, 1'b0, 10'h000, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 10'h000, 32'h0, 4'h0};
        vecs[4] = '{1'b1, 10'h010, 32'h0000AB00, 4'h2, 1'b0, 10'h000, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1, 10'h010, 32'h0000AB00, 4'h2};
        vecs[5] = '{1'b1, 10'h010, 32'hFFFFFFFF, 4'h0, 1'b0, 10'h000, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1, 10'h010, 32'hFFFFFFFF, 4'h0};
        vecs[6] = '{1'b1, 10'h030, 32'hAAAA0001, 4'hF, 1'b1, 10'h031, 32'hBBBB0001, 4'hF, 1'b1, 1'b0, 1'b1, 10'h030, 32'hAAAA0001, 4'hF};
        vecs[7] = '{1'b1, 10'h032, 32'hAAAA0002, 4'h3, 1'b1, 10'h033, 32'hBBBB0002, 4'hC, 1'b1, 1'b0, 1'b1, 10'h032, 32'hAAAA0002, 4'h3};
        vecs[8] = '{1'b0, 10'h000, 32'h0, 4'h0, 1'b1, 10'h000, 32'h00000001, 4'h1, 1'b0, 1'b1, 1'b1, 10'h000, 32'h00000001, 4'h1};

        repeat (2) @(posedge clk);
        do_reset();

        // Single-cycle write grants; the bank stays idle between rows.
        last_m = 1'b1;
        for (int v = 0; v < 9; v++) begin
            @(posedge clk); #1;
            a_req = vecs[v].a_req; a_we = 1; a_addr = vecs[v].a_addr; a_wdata = vecs[v].a_wdata; a_wben = vecs[v].a_wben;
            b_req = vecs[v].b_req; b_we = 1; b_addr = vecs[v].b_addr; b_wdata = vecs[v].b_wdata; b_wben = vecs[v].b_wben;
            e_a = vecs[v].e_a_gnt; e_b = vecs[v].e_b_gnt;
            e_addr = vecs[v].e_waddr; e_data = vecs[v].e_wdata; e_be = vecs[v].e_wben;
`ifdef BRAM_ARB_RR_EN
            if (vecs[v].a_req && vecs[v].b_req && !last_m) begin
                e_a = 0; e_b = 1;
                e_addr = vecs[v].b_addr; e_data = vecs[v].b_wdata; e_be = vecs[v].b_wben;
            end
`endif
            if (e_a) last_m = 1'b0;
            else if (e_b) last_m = 1'b1;
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                chk("wr_ctrl", i, {28'b0, a_gnt[i], b_gnt[i], ram_we[i], ram_re[i]}, {28'b0, e_a, e_b, vecs[v].e_we, 1'b0});
                chk("wr_waddr", i, {22'b0, ram_waddr[i]}, {22'b0, e_addr});
                chk("wr_wdata", i, ram_wdata[i], e_data);
                chk("wr_wben", i, {28'b0, ram_wben[i]}, {28'b0, e_be});
            end
            $display("vec %0d a_req=%b b_req=%b exp_gnt=%b%b addr=%h", v, vecs[v].a_req, vecs[v].b_req, e_a, e_b, e_addr);
        end
        @(posedge clk); #1;
        a_req = 0; b_req = 0;

        do_read(1'b0, 10'h005, 32'hDEADBEEF);
        do_read(1'b0, 10'h010, 32'h1122AB44);

        // Both ports read continuously.
        do_reset();
        ng = '{0, 0};
        last_own = '{0, 0};
        @(posedge clk); #1;
        a_req = 1; a_we = 0; a_addr = 10'h005;
        b_req = 1; b_we = 0; b_addr = 10'h3FF;
        for (int cyc = 0; cyc < 15; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (a_rvalid[i] || b_rvalid[i])
                    chk("contend_owner", i, {30'b0, a_rvalid[i], b_rvalid[i]}, last_own[i] ? 32'd1 : 32'd2);
                if (a_gnt[i] || b_gnt[i]) begin
`ifdef BRAM_ARB_RR_EN
                    e_b = ng[i][0];
`else
                    e_b = 1'b0;
`endif
                    chk("contend_order", i, {30'b0, a_gnt[i], b_gnt[i]}, e_b ? 32'd1 : 32'd2);
                    last_own[i] = b_gnt[i];
                    ng[i]++;
                end
            end
        end
        chk("contend_count", 0, ng[0], 5);
        chk("contend_count", 1, ng[1], 3);
        $display("contention run grants inst0=%0d inst1=%0d", ng[0], ng[1]);
        @(posedge clk); #1;
        a_req = 0; b_req = 0;
        idle_cycles(6);

        // B read at the top address, aborted by reset in the wait state.
        b_req = 1; b_we = 0; b_addr = 10'h3FF;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("abort_gnt", i, {31'b0, b_gnt[i]}, 1);
            chk("abort_raddr", i, {22'b0, ram_raddr[i]}, 32'h3FF);
        end
        @(posedge clk); #1;
        b_req = 0; reset = 1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) chk("abort_outputs", i, outs_or(i), 0);
        @(posedge clk); #1;
        reset = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) chk("abort_no_rvalid", i, {30'b0, a_rvalid[i], b_rvalid[i]}, 0);
        end
        @(posedge clk); #1;
        a_req = 1; a_we = 1; a_addr = 10'h040; a_wdata = 32'h12345678; a_wben = 4'hF;
        @(negedge clk);
        for (int i = 0; i < 2; i++) chk("abort_next_gnt", i, {30'b0, a_gnt[i], ram_we[i]}, 3);
        $display("reset abort of B read at 3FF, then A write granted");
        @(posedge clk); #1;
        a_req = 0;

        // B read holds off a waiting A request until after b_rvalid.
        b_cyc = '{0, 0};
        a_cyc = '{0, 0};
        @(posedge clk); #1;
        b_req = 1; b_we = 0; b_addr = 10'h3FF;
        @(negedge clk);
        for (int i = 0; i < 2; i++) chk("hold_b_gnt", i, {31'b0, b_gnt[i]}, 1);
        @(posedge clk); #1;
        b_req = 0; a_req = 1; a_we = 0; a_addr = 10'h005;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (b_rvalid[i] && b_cyc[i] == 0) begin
                    b_cyc[i] = cyc;
                    chk("hold_b_rdata", i, b_rdata[i], 32'hCAFEF00D);
                end
                if (a_gnt[i] && a_cyc[i] == 0) a_cyc[i] = cyc;
            end
            if (a_cyc[1] != 0 && a_req) begin
                @(posedge clk); #1;
                a_req = 0;
            end
        end
        for (int i = 0; i < 2; i++) begin
            chk("hold_b_rvalid_cyc", i, b_cyc[i], lat_of[i] + 1);
            chk("hold_a_gnt_cyc", i, a_cyc[i], lat_of[i] + 2);
        end
        $display("hold-off run b_rvalid=%0d/%0d a_gnt=%0d/%0d", b_cyc[0], b_cyc[1], a_cyc[0], a_cyc[1]);
        a_req = 0;
        idle_cycles(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
